// File: rtl/mac_tb_gen.sv
// Test-frame MAC sequencer: while insig is high, emits HEAD / DATA / GAP frames with
// a PRBS-driven modulation command in the DATA phase. All outputs are registered.
module mac_tb_gen #(
  parameter int         CLKS_PER_BIT = 10,
  parameter int         HEAD_BITS    = 192,
  parameter int         DATA_BITS    = 256,
  parameter int         GAP_BITS     = 100,
  parameter logic [6:0] LFSR_SEED    = 7'h5B
) (
  input  logic clock,
  input  logic reset,
  input  logic insig,
  output logic sending,
  output logic head,
  output logic datacmd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [15:0] CYC_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HEAD_LAST = 16'(HEAD_BITS - 1);
  localparam logic [15:0] DATA_LAST = 16'(DATA_BITS - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_BITS - 1);

  // x^7 + x^4 + 1, shifted MSB-first so lfsr[6] is always the current data bit
  function automatic logic [6:0] lfsr_next(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[3]};
  endfunction

  state_t      r_state;
  logic        r_sync1;
  logic        r_insig_s;
  logic [15:0] r_cyc_cnt;
  logic [15:0] r_bit_cnt;
  logic [6:0]  r_lfsr;
  logic        r_sending;
  logic        r_head;
  logic        r_datacmd;
  logic        w_bit_tick;
  logic        w_phase_end;
  logic [15:0] w_bit_last;

  assign w_bit_tick  = (r_cyc_cnt == CYC_LAST);
  assign w_phase_end = w_bit_tick && (r_bit_cnt == w_bit_last);

  assign sending = r_sending;
  assign head    = r_head;
  assign datacmd = r_datacmd;

  // Two-flop synchronizer for the asynchronous frame enable
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b0;
      r_insig_s <= 1'b0;
    end else begin
      r_sync1   <= insig;
      r_insig_s <= r_sync1;
    end
  end

  // Last bit index of the current phase
  always_comb begin
    w_bit_last = 16'd0;
    case (r_state)
      HEAD:    w_bit_last = HEAD_LAST;
      DATA:    w_bit_last = DATA_LAST;
      GAP:     w_bit_last = GAP_LAST;
      default: w_bit_last = 16'd0;
    endcase
  end

  // Frame FSM with counters, PRBS and registered outputs set from the next state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cyc_cnt <= 16'd0;
      r_bit_cnt <= 16'd0;
      r_lfsr    <= LFSR_SEED;
      r_sending <= 1'b0;
      r_head    <= 1'b0;
      r_datacmd <= 1'b0;
    end else begin
      r_cyc_cnt <= w_bit_tick ? 16'd0 : r_cyc_cnt + 16'd1;
      r_bit_cnt <= w_bit_tick ? r_bit_cnt + 16'd1 : r_bit_cnt;
      case (r_state)
        IDLE: begin
          r_cyc_cnt <= 16'd0;
          r_bit_cnt <= 16'd0;
          r_datacmd <= 1'b0;
          if (r_insig_s) begin
            r_state   <= HEAD;
            r_lfsr    <= LFSR_SEED;
            r_sending <= 1'b1;
            r_head    <= 1'b1;
          end else begin
            r_state   <= IDLE;
            r_sending <= 1'b0;
            r_head    <= 1'b0;
          end
        end
        HEAD: begin
          r_sending <= 1'b1;
          if (w_phase_end) begin
            r_state   <= DATA;
            r_cyc_cnt <= 16'd0;
            r_bit_cnt <= 16'd0;
            r_head    <= 1'b0;
            r_datacmd <= r_lfsr[6];
          end else begin
            r_head    <= 1'b1;
            r_datacmd <= 1'b0;
          end
        end
        DATA: begin
          r_head <= 1'b0;
          if (w_bit_tick) begin
            r_lfsr <= lfsr_next(r_lfsr);
          end else begin
            r_lfsr <= r_lfsr;
          end
          if (w_phase_end) begin
            r_state   <= GAP;
            r_cyc_cnt <= 16'd0;
            r_bit_cnt <= 16'd0;
            r_sending <= 1'b0;
            r_datacmd <= 1'b0;
          end else begin
            r_sending <= 1'b1;
            // at a bit tick the next bit is the one about to shift into lfsr[6]
            r_datacmd <= w_bit_tick ? r_lfsr[5] : r_lfsr[6];
          end
        end
        GAP: begin
          r_sending <= 1'b0;
          r_head    <= 1'b0;
          r_datacmd <= 1'b0;
          if (w_phase_end) begin
            r_state   <= IDLE;
            r_cyc_cnt <= 16'd0;
            r_bit_cnt <= 16'd0;
          end else begin
            r_state <= GAP;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_cyc_cnt <= 16'd0;
          r_bit_cnt <= 16'd0;
          r_sending <= 1'b0;
          r_head    <= 1'b0;
          r_datacmd <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tb_gen.sv
// Bench for mac_tb_gen: frame-position model checked every cycle, plus directed
// measurements of latency, phase lengths, first PRBS bits, enable drop and async reset.
module tb_mac_tb_gen;

  localparam int HEAD_CYC  = 1920;
  localparam int DATA_CYC  = 2560;
  localparam int FRAME_CYC = 5480;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic insig = 1'b0;
  logic sending;
  logic head;
  logic datacmd;

  int   checks   = 0;
  int   failures = 0;
  int   m_pos    = -1;
  logic m_s1     = 1'b0;
  logic m_s2     = 1'b0;
  logic prbs [0:255];

  mac_tb_gen dut (
    .clock  (clock),
    .reset  (reset),
    .insig  (insig),
    .sending(sending),
    .head   (head),
    .datacmd(datacmd)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, got, exp, $time);
    end
  endtask

  // Model: position within the frame (-1 = idle), frame starts once the synced enable is seen
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pos <= -1;
      m_s1  <= 1'b0;
      m_s2  <= 1'b0;
    end else begin
      m_s1 <= insig;
      m_s2 <= m_s1;
      if (m_pos >= 0 && m_pos < FRAME_CYC - 1) m_pos <= m_pos + 1;
      else if (m_pos == -1 && m_s2) m_pos <= 0;
      else m_pos <= -1;
    end
  end

  function automatic int model_out(input int pos);
    logic s, h, d;
    s = (pos >= 0) && (pos < HEAD_CYC + DATA_CYC);
    h = (pos >= 0) && (pos < HEAD_CYC);
    d = 1'b0;
    if (s && !h) d = prbs[(pos - HEAD_CYC) / 10];
    return int'({s, h, d});
  endfunction

  always @(negedge clock) begin
    check("outputs_vs_model", int'({sending, head, datacmd}), model_out(m_pos));
  end

  task automatic start_latency(output int k);
    k = 0;
    while (!sending && k < 8) begin
      @(negedge clock);
      k++;
    end
  endtask

  task automatic count_while(input int sel, input logic val, input int limit, output int n);
    n = 0;
    while (((sel == 0) ? sending : head) == val && n < limit) begin
      n++;
      @(negedge clock);
    end
  endtask

  initial begin
    logic [6:0]  seed;
    logic [12:0] pin;
    logic [6:0]  bits;
    int n, k, h_len, d_len, g_len;

    seed = 7'h5B;
    for (int i = 0; i < 7; i++) prbs[i] = seed[6-i];
    for (int i = 7; i < 256; i++) prbs[i] = prbs[i-7] ^ prbs[i-4];
    pin = 13'b1011011000001;
    for (int i = 0; i < 13; i++) check("prbs_pin", int'(prbs[i]), int'(pin[12-i]));

    // Reset held with enable high
    #1 reset = 1'b0;
    insig = 1'b1;
    repeat (10) @(negedge clock);
    check("reset_outputs", int'({sending, head, datacmd}), 0);

    // Start latency and first frame
    reset = 1'b1;
    start_latency(k);
    check("start_latency", k, 3);
    check("head_at_start", int'(head), 1);
    count_while(1, 1'b1, 4000, h_len);
    check("head_len", h_len, 1920);
    check("sending_in_data", int'(sending), 1);
    for (int i = 0; i < 7; i++) begin
      bits[6-i] = datacmd;
      repeat (10) @(negedge clock);
    end
    check("first_data_bits", int'(bits), 91);
    count_while(0, 1'b1, 4000, d_len);
    check("data_len", d_len + 70, 2560);
    count_while(0, 1'b0, 2000, g_len);
    check("gap_low_len", g_len, 1001);
    check("frame_period", h_len + 70 + d_len + g_len, 5481);

    // Second frame, enable dropped mid-DATA
    count_while(1, 1'b1, 4000, n);
    check("head_len_2", n, 1920);
    repeat (500) @(negedge clock);
    insig = 1'b0;
    count_while(0, 1'b1, 4000, n);
    check("drop_data_rest", n, 2060);
    count_while(0, 1'b0, 6000, n);
    check("no_new_frame", n, 6000);
    insig = 1'b1;
    start_latency(k);
    check("restart_latency", k, 3);

    // Asynchronous reset mid-HEAD
    repeat (100) @(negedge clock);
    check("head_before_reset", int'(head), 1);
    @(posedge clock);
    #2 reset = 1'b0;
    #1 check("async_reset_outputs", int'({sending, head, datacmd}), 0);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    start_latency(k);
    check("post_reset_latency", k, 3);
    count_while(1, 1'b1, 4000, n);
    check("post_reset_head_len", n, 1920);
    repeat (20) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
